mmio_ctrl: RTL
==============

MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, data and address width; legal values are 32 only.
REQ-002 SHALL have parameter NUM_OUT, default 4, number of output port registers; legal range is 1..8.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_FF00, word-aligned base of the register window.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port addr, input, BUS_WIDTH bits: byte address from the core's data path.
REQ-007 SHALL have port wr_data, input, BUS_WIDTH bits: store data, right-aligned.
REQ-008 SHALL have port wr_en, input, 1 bit: store strobe.
REQ-009 SHALL have port size, input, 2 bits: access size, with 00 = byte, 01 = half, 10 = word, and 11 treated as word.
REQ-010 SHALL have port sz_ex, input, 1 bit: load sign-extend when 1, zero-extend when 0.
REQ-011 SHALL have port in_port, input, BUS_WIDTH bits: asynchronous external input.
REQ-012 SHALL have port hit, output, 1 bit: addr lies in the window and the access is aligned.
REQ-013 SHALL have port rd_data, output, BUS_WIDTH bits: combinational load data.
REQ-014 SHALL have port out_ports, output, NUM_OUT*BUS_WIDTH bits: concatenated output registers, with OUT0 in the LSBs.
REQ-015 SHALL have port irq, output, 1 bit: timer interrupt request.

Function
REQ-016 SHALL decode word index W = (addr - BASE_ADDR) >> 2; window spans W = 0..NUM_OUT+3.
REQ-017 SHALL map W = 0..NUM_OUT-1 to OUTi (read/write).
REQ-018 SHALL map W = NUM_OUT to IN (read-only).
REQ-019 SHALL map W = NUM_OUT+1 to CNT, W = NUM_OUT+2 to CMP, and W = NUM_OUT+3 to CSR.
REQ-020 SHALL define CSR bits: bit0 EN, bit1 AUTO, bit2 PEND (write 1 to clear), bit3 IE; all other bits read 0.
REQ-021 SHALL treat as aligned: byte always; half when addr[0]=0; word when addr[1:0]=00; misaligned or out-of-window accesses give hit=0, rd_data=0, and no state change.
REQ-022 SHALL on a store with hit=1 update only the addressed lanes: byte writes lane addr[1:0] from wr_data[7:0]; half writes lane addr[1] from wr_data[15:0]; word writes all lanes.
REQ-023 SHALL ignore stores to IN.
REQ-024 SHALL build rd_data combinationally: select the addressed lane(s), right-align, extend per sz_ex.
REQ-025 SHALL double-flop in_port; IN reads return the second stage, so latency is 2 cycles from in_port change to visibility.
REQ-026 SHALL evaluate the timer every cycle with EN=1: if CNT==CMP, set PEND and either load CNT with 0 (AUTO=1) or hold CNT and clear EN (AUTO=0); otherwise increment CNT with 32-bit wrap.
REQ-027 SHALL hold CNT with EN=0.
REQ-028 SHALL give a software store to CNT or CSR.EN priority over the timer update in the same cycle; a match detected in that cycle still sets PEND.
REQ-029 SHALL give PEND-set priority over a write-1 clear of PEND in the same cycle.
REQ-030 SHALL drive irq = PEND & IE as a registered-state output with no combinational path from inputs.
REQ-031 SHALL apply every register update on the clk edge following the strobe; a store is visible to a load in the next cycle.

Reset
REQ-032 SHALL on rst=1 clear immediately and asynchronously all OUTi, CNT, CSR, and both sync stages, and set CMP to all-ones.
REQ-033 SHALL hold irq=0 and out_ports=0 during reset.
REQ-034 SHALL on reset asserted mid-count discard the count, with the timer restarting only after software sets EN.

Verification
REQ-035 SHALL cover: after reset, a word load from BASE_ADDR -> 0, a load from CMP address -> 32'hFFFF_FFFF, and irq=0.
REQ-036 SHALL cover: byte store 8'hA5 to BASE_ADDR+2 -> OUT0 = 32'h00A5_0000; byte load of the same address with sz_ex=1 -> 32'hFFFF_FFA5, with sz_ex=0 -> 32'h0000_00A5.
REQ-037 SHALL cover: half store to BASE_ADDR+1 -> hit=0 and OUT0 unchanged; word store to BASE_ADDR+4*(NUM_OUT+4) -> hit=0 and no change.
REQ-038 SHALL cover: CMP=3, CSR=4'b1011 -> PEND set on the cycle CNT==3, irq high the next cycle, CNT sequence 0,1,2,3,0,1; writing CSR=4'b1111 clears PEND (irq drops) unless a match occurs the same cycle.
REQ-039 SHALL cover: CMP=2, AUTO=0 -> CNT stops at 2 and EN reads 0; a store CNT=5 coincident with a match -> CNT=5 next cycle and PEND=1.
REQ-040 SHALL cover: in_port changes to 32'h1234_5678 -> IN load returns the new value exactly 2 cycles later; rst pulse mid-count -> all registers at reset values with no clock edge required.

Source files
------------

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: memory-mapped I/O block with output port registers, a
// synchronised input port and a compare/match timer that raises irq.
// Register window (word index from BASE_ADDR):
//   0..NUM_OUT-1 OUTi, NUM_OUT IN, NUM_OUT+1 CNT, NUM_OUT+2 CMP, NUM_OUT+3 CSR
module mmio_ctrl #(
  parameter int                   BUS_WIDTH = 32,
  parameter int                   NUM_OUT   = 4,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR = 32'h0000_FF00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_WIDTH-1:0]         addr,
  input  logic [BUS_WIDTH-1:0]         wr_data,
  input  logic                         wr_en,
  input  logic [1:0]                   size,
  input  logic                         sz_ex,
  input  logic [BUS_WIDTH-1:0]         in_port,
  output logic                         hit,
  output logic [BUS_WIDTH-1:0]         rd_data,
  output logic [NUM_OUT*BUS_WIDTH-1:0] out_ports,
  output logic                         irq
);

  localparam int IW = BUS_WIDTH - 2;
  localparam logic [IW-1:0] WIN_WORDS = IW'(NUM_OUT + 4);
  localparam logic [IW-1:0] IDX_IN    = IW'(NUM_OUT);
  localparam logic [IW-1:0] IDX_CNT   = IW'(NUM_OUT + 1);
  localparam logic [IW-1:0] IDX_CMP   = IW'(NUM_OUT + 2);
  localparam logic [IW-1:0] IDX_CSR   = IW'(NUM_OUT + 3);

  // Merge store data into an existing word, touching only the addressed lanes.
  function automatic logic [BUS_WIDTH-1:0] store_merge(
    input logic [BUS_WIDTH-1:0] old_w,
    input logic [BUS_WIDTH-1:0] wd,
    input logic [1:0]           sz,
    input logic [1:0]           lane
  );
    logic [BUS_WIDTH-1:0] r;
    r = old_w;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Pick the addressed lane(s) of a word, right-align and extend.
  function automatic logic [BUS_WIDTH-1:0] load_extract(
    input logic [BUS_WIDTH-1:0] w,
    input logic [1:0]           sz,
    input logic [1:0]           lane,
    input logic                 sx
  );
    logic [7:0]           b;
    logic [15:0]          h;
    logic [BUS_WIDTH-1:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  logic [BUS_WIDTH-1:0] out_r [NUM_OUT];
  logic [BUS_WIDTH-1:0] sync1_r;
  logic [BUS_WIDTH-1:0] sync2_r;
  logic [BUS_WIDTH-1:0] cnt_r;
  logic [BUS_WIDTH-1:0] cmp_r;
  logic                 en_r;
  logic                 auto_r;
  logic                 pend_r;
  logic                 ie_r;
  logic                 irq_r;

  logic [BUS_WIDTH-1:0] offset_s;
  logic [IW-1:0]        word_idx_s;
  logic [1:0]           lane_s;
  logic                 in_window_s;
  logic                 aligned_s;
  logic                 hit_s;
  logic                 wr_hit_s;
  logic                 lane0_wr_s;
  logic [BUS_WIDTH-1:0] sel_word_s;
  logic [BUS_WIDTH-1:0] csr_rd_s;
  logic [BUS_WIDTH-1:0] csr_wdata_s;
  logic                 csr_wr_s;
  logic                 match_s;
  logic [BUS_WIDTH-1:0] cnt_nxt_s;
  logic [BUS_WIDTH-1:0] cmp_nxt_s;
  logic                 en_nxt_s;
  logic                 auto_nxt_s;
  logic                 pend_nxt_s;
  logic                 ie_nxt_s;

  assign csr_rd_s = {28'h000_0000, ie_r, pend_r, auto_r, en_r};

  // Address decode, alignment check and combinational load path.
  always_comb begin
    offset_s    = addr - BASE_ADDR;
    word_idx_s  = offset_s[BUS_WIDTH-1:2];
    lane_s      = addr[1:0];
    in_window_s = (word_idx_s < WIN_WORDS);
    case (size)
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr[0];
      default: aligned_s = (addr[1:0] == 2'b00);
    endcase
    hit_s    = in_window_s & aligned_s;
    wr_hit_s = hit_s & wr_en;
    case (size)
      2'b00:   lane0_wr_s = (lane_s == 2'b00);
      2'b01:   lane0_wr_s = ~lane_s[1];
      default: lane0_wr_s = 1'b1;
    endcase
    sel_word_s = {BUS_WIDTH{1'b0}};
    for (int i = 0; i < NUM_OUT; i++) begin
      if (word_idx_s == IW'(i)) begin
        sel_word_s = out_r[i];
      end else begin
        sel_word_s = sel_word_s;
      end
    end
    case (word_idx_s)
      IDX_IN:  sel_word_s = sync2_r;
      IDX_CNT: sel_word_s = cnt_r;
      IDX_CMP: sel_word_s = cmp_r;
      IDX_CSR: sel_word_s = csr_rd_s;
      default: sel_word_s = sel_word_s;
    endcase
    if (hit_s) begin
      rd_data = load_extract(sel_word_s, size, lane_s, sz_ex);
    end else begin
      rd_data = {BUS_WIDTH{1'b0}};
    end
  end

  assign hit = hit_s;

  // Timer evaluation and software-store priority for CNT/CMP/CSR.
  always_comb begin
    match_s     = en_r & (cnt_r == cmp_r);
    csr_wr_s    = wr_hit_s & (word_idx_s == IDX_CSR);
    // PEND is masked out of the merge base so only a freshly written 1 clears it
    csr_wdata_s = store_merge(csr_rd_s & ~32'h0000_0004, wr_data, size, lane_s);
    cnt_nxt_s   = cnt_r;
    en_nxt_s    = en_r;
    if (en_r) begin
      if (match_s) begin
        if (auto_r) begin
          cnt_nxt_s = {BUS_WIDTH{1'b0}};
        end else begin
          en_nxt_s = 1'b0;
        end
      end else begin
        cnt_nxt_s = cnt_r + 32'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
    if (wr_hit_s && (word_idx_s == IDX_CNT)) begin
      cnt_nxt_s = store_merge(cnt_r, wr_data, size, lane_s);
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
    if (wr_hit_s && (word_idx_s == IDX_CMP)) begin
      cmp_nxt_s = store_merge(cmp_r, wr_data, size, lane_s);
    end else begin
      cmp_nxt_s = cmp_r;
    end
    if (csr_wr_s && lane0_wr_s) begin
      en_nxt_s   = csr_wdata_s[0];
      auto_nxt_s = csr_wdata_s[1];
      ie_nxt_s   = csr_wdata_s[3];
    end else begin
      auto_nxt_s = auto_r;
      ie_nxt_s   = ie_r;
    end
    if (match_s) begin
      pend_nxt_s = 1'b1;
    end else if (csr_wr_s && csr_wdata_s[2]) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Output port registers; stores to IN fall outside this index range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out_r[i] <= {BUS_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr_hit_s && (word_idx_s == IW'(i))) begin
          out_r[i] <= store_merge(out_r[i], wr_data, size, lane_s);
        end
      end
    end
  end

  // Two-stage synchroniser for the asynchronous input port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {BUS_WIDTH{1'b0}};
      sync2_r <= {BUS_WIDTH{1'b0}};
    end else begin
      sync1_r <= in_port;
      sync2_r <= sync1_r;
    end
  end

  // Timer, compare and control/status state plus the registered irq.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {BUS_WIDTH{1'b0}};
      cmp_r  <= {BUS_WIDTH{1'b1}};
      en_r   <= 1'b0;
      auto_r <= 1'b0;
      pend_r <= 1'b0;
      ie_r   <= 1'b0;
      irq_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      cmp_r  <= cmp_nxt_s;
      en_r   <= en_nxt_s;
      auto_r <= auto_nxt_s;
      pend_r <= pend_nxt_s;
      ie_r   <= ie_nxt_s;
      irq_r  <= pend_nxt_s & ie_nxt_s;
    end
  end

  assign irq = irq_r;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_ports[g*BUS_WIDTH +: BUS_WIDTH] = out_r[g];
  end

endmodule
